uart_tx_ctrl: RTL

//  Frame sequencer for the UART transmitter. Accepts a byte-valid handshake and walks the frame:

---
 rtl/uart_tx_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, DATA_WIDTH data bits, optional parity, stop.
// Optional second stop bit when UART_TX_TWO_STOP_EN is defined.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_IDLE  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_en_q, par_en_d;
  logic [1:0]       mux_sel_q;
  logic             busy_q;

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      S_START:  sel_of = SEL_START;
      S_DATA:   sel_of = SEL_DATA;
      S_PARITY: sel_of = SEL_PAR;
      default:  sel_of = SEL_IDLE;
    endcase
  endfunction

  // Next-state logic; load/shift strobes are combinational so they act in the current cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    ser_load = 1'b0;
    ser_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          ser_load = 1'b1;
          par_en_d = PAR_EN;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (TICK) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (TICK) begin
          ser_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (TICK) begin
          state_d = S_STOP;
        end
      end
`ifdef UART_TX_TWO_STOP_EN
      S_STOP: begin
        if (TICK) begin
          state_d = S_STOP2;
        end
      end
      S_STOP2: begin
`else
      S_STOP: begin
`endif
        // Final stop tick doubles as an accept slot so frames run back-to-back.
        if (TICK) begin
          if (DATA_VALID) begin
            ser_load = 1'b1;
            par_en_d = PAR_EN;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      mux_sel_q <= SEL_IDLE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      mux_sel_q <= sel_of(state_d);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign mux_sel = mux_sel_q;
  assign busy    = busy_q;

endmodule
